exec_mdu: RTL and testbench
===========================

Name: exec_mdu

Overview:
- Parametrised multi-cycle multiply/divide execute unit for the RV32M/RV64M instructions.
- Sits beside the single-cycle integer ALU in the execute stage.
- Reuses the same 2-bit forwarding selection for its operands.
- Stalls the front of the pipeline through the hazard unit while it iterates.
- Hands a tagged result to the memory stage for one cycle.

Parameters:
- XLEN, 32, operand/result width; allowed values 32 or 64.
- BITS_PER_CYCLE, 1, bits retired per iteration step; allowed values 1, 2 or 4; must divide XLEN.
- N_STEPS, XLEN/BITS_PER_CYCLE, derived localparam; not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  decoded M-extension op valid in execute this cycle.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rd_in  in  5  destination register tag.
- rd1  in  XLEN  register-file operand A.
- rd2  in  XLEN  register-file operand B.
- forward_a  in  2  operand A source: 00 rd1, 01 result_w, 10 result_m, 11 imm_ext_m.
- forward_b  in  2  operand B source, same encoding as forward_a.
- result_w  in  XLEN  writeback-stage forward value.
- result_m  in  XLEN  memory-stage forward value, already selected ALU/FPU.
- imm_ext_m  in  XLEN  memory-stage immediate forward value.
- flush  in  1  kill in-flight op (branch/jump taken).
- stall_mdu  out  1  to hazard unit: hold fetch/decode/execute.
- done  out  1  result valid, one-cycle pulse.
- rd_out  out  5  tag of the completed op.
- result  out  XLEN  result of the completed op.
- busy  out  1  FSM not in IDLE or DONE.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; stall_mdu, done, busy = 0; result = 0; rd_out = 0; all internal registers cleared.
- Operand capture: forwarding muxes are combinational. Operands, funct3 and rd_in are latched on the rising edge where start=1 and state is IDLE or DONE. start in any other state is ignored; the hazard unit never issues one there.
- stall_mdu = start (when accepted) OR busy. It is combinational so the issuing instruction holds in execute until done.
- FSM states:
  - IDLE -> PREP on start.
  - PREP: take absolute values for the signed variants; record result sign; detect special cases.
    - Special case -> DONE.
    - Otherwise -> CALC, with step counter = 0.
  - CALC: shift-add multiply, or restoring divide, retiring BITS_PER_CYCLE bits per cycle. Counter increments. After N_STEPS cycles -> FIX.
  - FIX: apply sign correction; select low half (MUL), high half (MULH*), quotient or remainder. -> DONE.
  - DONE: done=1 for exactly one cycle; result and rd_out are valid and held until the next DONE.
    - -> PREP if start=1 this cycle (back-to-back issue).
    - Otherwise -> IDLE.
- Latency: start sampled at edge t gives done high in cycle t+N_STEPS+3. XLEN=32, BITS_PER_CYCLE=1 gives 35 cycles; BITS_PER_CYCLE=4 gives 11 cycles.
- Special cases (resolved in PREP, done at t+2):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): DIV = dividend; REM = 0.
  - Multiply has no fast path.
- Arithmetic:
  - Full 2*XLEN-bit product internally.
  - MULHSU treats A signed and B unsigned.
  - Signed remainder takes the dividend's sign; quotient truncates toward zero.
- flush=1: synchronous return to IDLE from any state next edge; no done pulse. result/rd_out keep their old values. flush and start in the same cycle: flush wins, op not accepted.
- busy and stall_mdu drop in the DONE cycle, so the stalled instruction advances exactly as done is presented.

Test Plan:
- XLEN=32, BPC=1: MUL 7 × -3 -> done at cycle 35, result 0xFFFFFFEB, rd_out matches; stall_mdu high cycles 0..34.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -1 × 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV x/0 -> 0xFFFFFFFF at cycle 2. REM 0x80000000 / -1 -> 0 at cycle 2. DIV 0x80000000 / -1 -> 0x80000000.
- Forwarding: forward_a=01, result_w=9, rd1=0, rd2=3, MUL -> 27. Back-to-back: start asserted during DONE, second op done N_STEPS+3 later, no idle gap.
- flush at cycle 10 of DIVU -> IDLE next edge, no done, stall_mdu low. Assert rst low mid-CALC -> all outputs 0 asynchronously. Repeat scenarios 1 and 3 with XLEN=64, BPC=4: latency 19.

Source files
------------

// File: rtl/exec_mdu_if.sv
// Issue/result bundle between the execute stage and the multi-cycle MDU.
// Operand sources, forward values and completion outputs travel together.
interface exec_mdu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [1:0]      forward_a;
    logic [1:0]      forward_b;
    logic [XLEN-1:0] result_w;
    logic [XLEN-1:0] result_m;
    logic [XLEN-1:0] imm_ext_m;
    logic            flush;
    logic            stall_mdu;
    logic            done;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output start, funct3, rd_in, rd1, rd2, forward_a, forward_b,
               result_w, result_m, imm_ext_m, flush,
        input  stall_mdu, done, rd_out, result, busy
    );

    modport slave (
        input  start, funct3, rd_in, rd1, rd2, forward_a, forward_b,
               result_w, result_m, imm_ext_m, flush,
        output stall_mdu, done, rd_out, result, busy
    );
endinterface

// File: rtl/exec_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, sign fixed up at the end, BITS_PER_CYCLE bits per step.
module exec_mdu #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    exec_mdu_if.slave  bus
);
    localparam int N_STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW      = $clog2(N_STEPS + 1);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] a_q, b_q, hi_q, lo_q, result_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q, rd_out_q;
    logic            neg_q;
    logic [CW-1:0]   cnt_q;

    logic [XLEN-1:0] op_a, op_b;
    logic            accept;

    always_comb begin
        case (bus.forward_a)
            2'b01:   op_a = bus.result_w;
            2'b10:   op_a = bus.result_m;
            2'b11:   op_a = bus.imm_ext_m;
            default: op_a = bus.rd1;
        endcase
        case (bus.forward_b)
            2'b01:   op_b = bus.result_w;
            2'b10:   op_b = bus.result_m;
            2'b11:   op_b = bus.imm_ext_m;
            default: op_b = bus.rd2;
        endcase
    end

    assign accept = bus.start && !bus.flush && (state_q == S_IDLE || state_q == S_DONE);

    // Opcode decode on the latched funct3
    logic is_div, is_rem, sgn_a, sgn_b, a_neg, b_neg, neg_d;
    logic [XLEN-1:0] abs_a, abs_b;
    logic div0, ovf, special;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        is_div = f3_q[2];
        is_rem = f3_q[2] & f3_q[1];
        sgn_a  = is_div ? !f3_q[0] : (f3_q[1:0] == 2'b01 || f3_q[1:0] == 2'b10);
        sgn_b  = is_div ? !f3_q[0] : (f3_q[1:0] == 2'b01);
        a_neg  = sgn_a & a_q[XLEN-1];
        b_neg  = sgn_b & b_q[XLEN-1];
        abs_a  = a_neg ? -a_q : a_q;
        abs_b  = b_neg ? -b_q : b_q;
        neg_d  = is_rem ? a_neg : (a_neg ^ b_neg);
        div0   = is_div && (b_q == '0);
        ovf    = is_div && sgn_a && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
        special = div0 | ovf;
        if (div0) spec_res = is_rem ? a_q : '1;
        else      spec_res = is_rem ? '0  : a_q;
    end

    // One CALC step: hi/lo act as {acc, multiplier} or {remainder, quotient}
    logic [XLEN-1:0] hi_n, lo_n;
    logic [XLEN:0]   sum;

    always_comb begin
        hi_n = hi_q;
        lo_n = lo_q;
        sum  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (!is_div) begin
                sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
                lo_n = {sum[0], lo_n[XLEN-1:1]};
                hi_n = sum[XLEN:1];
            end else begin
                sum  = {hi_n, lo_n[XLEN-1]};
                lo_n = {lo_n[XLEN-2:0], 1'b0};
                if (sum >= {1'b0, b_q}) begin
                    sum     = sum - {1'b0, b_q};
                    lo_n[0] = 1'b1;
                end
                hi_n = sum[XLEN-1:0];
            end
        end
    end

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = neg_q ? -prod : prod;
        if (!is_div)
            fix_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else if (is_rem)
            fix_res = neg_q ? -hi_q : hi_q;
        else
            fix_res = neg_q ? -lo_q : lo_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_PREP;
            S_PREP: state_d = special ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == CW'(N_STEPS - 1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = accept ? S_PREP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            if (accept) begin
                a_q  <= op_a;
                b_q  <= op_b;
                f3_q <= bus.funct3;
                rd_q <= bus.rd_in;
            end
            case (state_q)
                S_PREP: if (!bus.flush) begin
                    if (special) begin
                        result_q <= spec_res;
                        rd_out_q <= rd_q;
                    end else begin
                        hi_q  <= '0;
                        lo_q  <= abs_a;
                        b_q   <= abs_b;
                        neg_q <= neg_d;
                        cnt_q <= '0;
                    end
                end
                S_CALC: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_FIX: if (!bus.flush) begin
                    result_q <= fix_res;
                    rd_out_q <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.done      = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.stall_mdu = accept | bus.busy;
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_out_q;
endmodule

// File: tb/tb_exec_mdu.sv
// Directed bench: a 32-bit/1-bit-per-step and a 64-bit/4-bit-per-step MDU
// driven side by side with hand-computed results and latencies.
module tb_exec_mdu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exec_mdu_if #(.XLEN(32)) if32();
    exec_mdu_if #(.XLEN(64)) if64();

    exec_mdu #(.XLEN(32), .BITS_PER_CYCLE(1)) u32 (.clk(clk), .rst(rst), .bus(if32.slave));
    exec_mdu #(.XLEN(64), .BITS_PER_CYCLE(4)) u64 (.clk(clk), .rst(rst), .bus(if64.slave));

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0]  fa = 2'b00, fb = 2'b00;
    logic [63:0] fw = '0, fm = '0, fi = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic o_done(input bit w);  return w ? if64.done : if32.done; endfunction
    function automatic logic o_busy(input bit w);  return w ? if64.busy : if32.busy; endfunction
    function automatic logic o_stall(input bit w); return w ? if64.stall_mdu : if32.stall_mdu; endfunction
    function automatic logic [4:0] o_rd(input bit w); return w ? if64.rd_out : if32.rd_out; endfunction
    function automatic logic [63:0] o_res(input bit w);
        return w ? if64.result : {32'b0, if32.result};
    endfunction

    task automatic drive(input bit w, input bit st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        if (w) begin
            if64.start = st; if64.funct3 = f3; if64.rd_in = rd;
            if64.rd1 = a; if64.rd2 = b;
            if64.forward_a = fa; if64.forward_b = fb;
            if64.result_w = fw; if64.result_m = fm; if64.imm_ext_m = fi;
        end else begin
            if32.start = st; if32.funct3 = f3; if32.rd_in = rd;
            if32.rd1 = a[31:0]; if32.rd2 = b[31:0];
            if32.forward_a = fa; if32.forward_b = fb;
            if32.result_w = fw[31:0]; if32.result_m = fm[31:0]; if32.imm_ext_m = fi[31:0];
        end
    endtask

    // Issues at the current negedge (cycle 0), returns at the negedge of the done cycle
    task automatic run_op(input string tag, input bit w, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp, input int exp_lat);
        int lat = 0;
        int st_hi = 0;
        bit seen = 0;
        drive(w, 1'b1, f3, a, b, rd);
        #1 st_hi += int'(o_stall(w));
        @(posedge clk);
        #1 drive(w, 1'b0, 3'b000, '0, '0, 5'd0);
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(negedge clk);
            if (o_done(w)) begin seen = 1; lat = k; end
            else st_hi += int'(o_stall(w));
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, o_res(w), exp);
        chk({tag, " rd_out"}, 64'(o_rd(w)), 64'(rd));
        chk({tag, " stall cycles"}, 64'(st_hi), 64'(exp_lat));
        chk({tag, " stall@done"}, 64'(o_stall(w)), 64'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        drive(1'b0, 1'b0, 3'b000, '0, '0, 5'd0);
        drive(1'b1, 1'b0, 3'b000, '0, '0, 5'd0);
        if32.flush = 1'b0;
        if64.flush = 1'b0;
        #2;
        chk("rst result32", o_res(0), 64'd0);
        chk("rst rd32", 64'(o_rd(0)), 64'd0);
        chk("rst done32", 64'(o_done(0)), 64'd0);
        chk("rst busy32", 64'(o_busy(0)), 64'd0);
        chk("rst stall32", 64'(o_stall(0)), 64'd0);
        chk("rst result64", o_res(1), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);

        run_op("mul32", 0, 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'h0000_0000_FFFF_FFEB, 35);
        idle(1);
        chk("done pulse width", 64'(o_done(0)), 64'd0);
        chk("busy after done", 64'(o_busy(0)), 64'd0);
        run_op("mulhu", 0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd6, 64'hFFFF_FFFE, 35);
        idle(1);
        run_op("mulh", 0, 3'b001, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd7, 64'h0, 35);
        idle(1);
        run_op("mulhsu", 0, 3'b010, 64'hFFFF_FFFF, 64'd2, 5'd8, 64'hFFFF_FFFF, 35);
        idle(1);
        run_op("div32", 0, 3'b100, 64'hFFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFD, 35);
        idle(1);
        run_op("rem32", 0, 3'b110, 64'hFFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFF, 35);
        idle(1);
        run_op("divu32", 0, 3'b101, 64'd100, 64'd7, 5'd11, 64'd14, 35);
        idle(1);
        run_op("remu32", 0, 3'b111, 64'd100, 64'd7, 5'd12, 64'd2, 35);
        idle(1);

        // flush during CALC of a DIVU: no done, outputs keep the REMU result
        drive(0, 1'b1, 3'b101, 64'd200, 64'd3, 5'd20);
        @(posedge clk);
        #1 drive(0, 1'b0, 3'b000, '0, '0, 5'd0);
        idle(10);
        if32.flush = 1'b1;
        @(posedge clk);
        #1 if32.flush = 1'b0;
        chk("flush busy", 64'(o_busy(0)), 64'd0);
        chk("flush stall", 64'(o_stall(0)), 64'd0);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            cnt += int'(o_done(0));
        end
        chk("flush no done", 64'(cnt), 64'd0);
        chk("flush result held", o_res(0), 64'd2);
        chk("flush rd held", 64'(o_rd(0)), 64'd12);

        // flush and start together: op not accepted
        drive(0, 1'b1, 3'b000, 64'd3, 64'd3, 5'd21);
        if32.flush = 1'b1;
        #1 chk("flush+start stall", 64'(o_stall(0)), 64'd0);
        @(posedge clk);
        #1 begin drive(0, 1'b0, 3'b000, '0, '0, 5'd0); if32.flush = 1'b0; end
        @(negedge clk);
        chk("flush+start busy", 64'(o_busy(0)), 64'd0);

        run_op("div0", 0, 3'b100, 64'd5, 64'd0, 5'd13, 64'hFFFF_FFFF, 2);
        idle(1);
        run_op("remu0", 0, 3'b111, 64'd9, 64'd0, 5'd14, 64'd9, 2);
        idle(1);
        run_op("rem ovf", 0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 5'd15, 64'd0, 2);
        idle(1);
        run_op("div ovf", 0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 5'd16, 64'h8000_0000, 2);
        idle(1);

        fa = 2'b01; fw = 64'd9;
        run_op("fwd a=w", 0, 3'b000, 64'd0, 64'd3, 5'd17, 64'd27, 35);
        idle(1);
        fa = 2'b00; fb = 2'b10; fm = 64'd5;
        run_op("fwd b=m", 0, 3'b000, 64'd6, 64'd0, 5'd18, 64'd30, 35);
        idle(1);
        fa = 2'b11; fb = 2'b00; fi = 64'd4;
        run_op("fwd a=imm", 0, 3'b000, 64'd0, 64'd5, 5'd19, 64'd20, 35);
        fa = 2'b00;
        idle(1);

        // back-to-back: second op issued in the first op's DONE cycle
        run_op("b2b first", 0, 3'b101, 64'd50, 64'd5, 5'd22, 64'd10, 35);
        run_op("b2b second", 0, 3'b000, 64'd11, 64'd12, 5'd23, 64'd132, 35);
        idle(1);

        // asynchronous reset mid-CALC
        drive(0, 1'b1, 3'b000, 64'd3, 64'd4, 5'd24);
        @(posedge clk);
        #1 drive(0, 1'b0, 3'b000, '0, '0, 5'd0);
        idle(5);
        rst = 1'b0;
        #1;
        chk("arst result", o_res(0), 64'd0);
        chk("arst rd", 64'(o_rd(0)), 64'd0);
        chk("arst busy", 64'(o_busy(0)), 64'd0);
        chk("arst stall", 64'(o_stall(0)), 64'd0);
        chk("arst done", 64'(o_done(0)), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);

        run_op("mul64", 1, 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd25, 64'hFFFF_FFFF_FFFF_FFEB, 19);
        idle(1);
        run_op("div64", 1, 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd26, 64'hFFFF_FFFF_FFFF_FFFD, 19);
        idle(1);
        run_op("rem64", 1, 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd27, 64'hFFFF_FFFF_FFFF_FFFF, 19);
        idle(1);
        run_op("divu64", 1, 3'b101, 64'd100, 64'd7, 5'd28, 64'd14, 19);
        idle(1);
        run_op("remu64", 1, 3'b111, 64'd100, 64'd7, 5'd29, 64'd2, 19);
        idle(1);
        run_op("mulhu64", 1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd30,
               64'hFFFF_FFFF_FFFF_FFFE, 19);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
